// File: rtl/pipelined_csa_adder.sv
// pipelined_csa_adder: carry-select adder/subtractor, one BLK-bit block resolved per stage,
// valid/ready handshake with full-pipeline stall and bubble collapse.
module pipelined_csa_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLK;

    logic [NBLK-1:0] w_v;
    logic [NBLK-1:0] w_en;
    logic            w_xfer;

    assign out_valid = w_v[NBLK-1];
    assign in_ready  = !out_valid || out_ready;
    assign w_xfer    = in_valid && in_ready;

    genvar k;
    for (k = 0; k < NBLK; k++) begin : g_st
        // r_a: resolved sum blocks enter at the top while pending A blocks shift down to bit 0
        logic                    r_v;
        logic                    r_c;
        logic [WIDTH-1:0]        r_a;
        logic [WIDTH-k*BLK-1:0]  r_b;
        logic [BLK:0]            w_s0;
        logic [BLK:0]            w_s1;
        logic [BLK:0]            w_r;

        assign w_v[k]  = r_v;
        assign w_en[k] = out_ready || !(&w_v[NBLK-1:k]);
        assign w_s0    = {1'b0, r_a[BLK-1:0]} + {1'b0, r_b[BLK-1:0]};
        assign w_s1    = {1'b0, r_a[BLK-1:0]} + {1'b0, r_b[BLK-1:0]} + (BLK+1)'(1);
        assign w_r     = r_c ? w_s1 : w_s0;

        if (k == 0) begin : g_in
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en[k]) begin
                    r_v <= w_xfer;
                    if (w_xfer) begin
                        r_a <= a;
                        r_b <= sub ? ~b : b;
                        r_c <= sub | c_in;
                    end
                end
            end
        end else begin : g_pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en[k]) begin
                    r_v <= g_st[k-1].r_v;
                    r_c <= g_st[k-1].w_r[BLK];
                    r_a <= {g_st[k-1].w_r[BLK-1:0], g_st[k-1].r_a[WIDTH-1:BLK]};
                    r_b <= g_st[k-1].r_b[WIDTH-(k-1)*BLK-1:BLK];
                end
            end
        end
    end

    assign c_out = g_st[NBLK-1].w_r[BLK];
    assign ovf   = g_st[NBLK-1].r_a[BLK-1] ^ g_st[NBLK-1].r_b[BLK-1] ^ g_st[NBLK-1].w_r[BLK-1] ^ c_out;

    if (NBLK == 1) begin : g_one
        assign sum = g_st[0].w_r[BLK-1:0];
    end else begin : g_many
        assign sum = {g_st[NBLK-1].w_r[BLK-1:0], g_st[NBLK-1].r_a[WIDTH-1:BLK]};
    end
endmodule

// File: tb/tb_pipelined_csa_adder.sv
// tb_pipelined_csa_adder: directed and randomized checks of the pipelined carry-select adder.
module tb_pipelined_csa_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_csa_adder #(.WIDTH(16), .BLK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic s);
        logic [15:0] ye;
        logic [16:0] r;
        logic        o;
        ye = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + 17'(s ? 1'b1 : ci);
        o  = (x[15] == ye[15]) && (r[15] != x[15]);
        return {o, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'hA5A5; b = 16'h5A5A; c_in = 1'b1; sub = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0 || c_out !== 1'b0 || ovf !== 1'b0)
            $display("FAIL reset_state: valid=%b ready=%b sum=%h c=%b o=%b, required 0 1 0000 0 0",
                     out_valid, in_ready, sum, c_out, ovf);
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0 || c_out !== 1'b0 || ovf !== 1'b0)
            n_fail++;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignores_in: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_vector(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                               input logic vs, input logic [15:0] es, input logic ec,
                               input logic eo, input string nm);
        @(negedge clk);
        a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = ~vc; sub = ~vs;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_early: out_valid=%b at cycle %0d, required 0", nm, out_valid, i);
            end
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b1 || sum !== es || c_out !== ec || ovf !== eo) begin
            n_fail++;
            $display("FAIL %s: valid=%b sum=%h c=%b o=%b, required 1 %h %b %b",
                     nm, out_valid, sum, c_out, ovf, es, ec, eo);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_dup: out_valid=%b after consume, required 0", nm, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          recv = 0;
        logic        held = 1'b0;
        logic        saw_block = 1'b0;
        logic [16:0] hs = '0;
        logic [15:0] es;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 10);
            a = 16'(16'h0111 * sent); b = 16'hF0F0; c_in = 1'b0; sub = 1'b0;
            out_ready = !(cyc >= 5 && cyc <= 8);
            #1;
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || {c_out, sum} !== hs) begin
                    n_fail++;
                    $display("FAIL b2b_hold: valid=%b c/sum=%h, required 1 %h", out_valid, {c_out, sum}, hs);
                end
            end
            if (out_valid && !out_ready) begin
                saw_block = saw_block | !in_ready;
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_stall_ready: in_ready=%b required 0", in_ready);
                end
            end
            held = out_valid && !out_ready;
            hs = {c_out, sum};
            if (out_valid && out_ready) begin
                es = 16'(16'h0111 * recv + 16'hF0F0);
                n_checks++;
                if (recv >= 10 || sum !== es) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: sum=%h required %h", recv, sum, es);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv !== 10 || !saw_block) begin
            n_fail++;
            $display("FAIL b2b_count: received=%0d blocked=%b, required 10 1", recv, saw_block);
        end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; c_in = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'(16'h1000 * (i + 1)); b = 16'h0001;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: out_valid=%b required 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0 || c_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: valid=%b ready=%b sum=%h c=%b, required 0 1 0000 0",
                     out_valid, in_ready, sum, c_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL midreset_stale: %0d stale results, required 0", stale);
        end
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] e;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        while (recv < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom);
            c_in = 1'($urandom); sub = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: unexpected result sum=%h", sum);
                end else begin
                    e = q.pop_front();
                    if ({ovf, c_out, sum} !== e) begin
                        n_fail++;
                        $display("FAIL rand[%0d]: o/c/sum=%h required %h", recv, {ovf, c_out, sum}, e);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_add(a, b, c_in, sub));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv !== 10000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: received=%0d pending=%0d, required 10000 0", recv, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_vector(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "add_basic");
        test_vector(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_all");
        test_vector(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        test_vector(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        test_vector(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        test_vector(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_neg_ovf");
        test_vector(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_ignores_cin");
        test_vector(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "block_carry");
        test_back_to_back();
        test_reset_midflight();
        test_vector(16'h4321, 16'h1234, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "resume");
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
